// File: rtl/fft_pkg.sv
// Shared FFT constants, the bit-reversal helper and the reorder-reader state type.
// R2SDF_FFT uses the same bitrev for its own address generation.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int LOG2N  = 4;
  localparam int N      = 1 << LOG2N;

  typedef enum logic {
    IDLE,
    STREAM
  } rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N-entry frame bank: synchronous write port, asynchronous read port.
module fft_reorder_bank
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  en,
  input  logic [LOG2N-1:0]      addr,
  input  logic [2*DATA_W-1:0]   data,
  input  logic [LOG2N-1:0]      raddr,
  output logic [2*DATA_W-1:0]   rdata
);

  logic [2*DATA_W-1:0] mem [N];

  // NOTE: the array is deliberately not reset; the full flags in the top level
  // guarantee no entry is read before a complete frame has been written.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= data;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder_reader.sv
// Natural-order output stage: stores bit-reversed FFT frames in a ping-pong bank
// pair and streams them out in bin order over valid/ready.
module fft_reorder_reader
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              di_en,
  input  logic [DATA_W-1:0] di_re,
  input  logic [DATA_W-1:0] di_im,
  output logic              do_valid,
  input  logic              do_ready,
  output logic [DATA_W-1:0] do_re,
  output logic [DATA_W-1:0] do_im,
  output logic [LOG2N-1:0]  do_index,
  output logic              do_last,
  output logic              frame_drop
);

  localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(N - 1);

  logic [LOG2N-1:0]    wcnt;
  logic                wbank;
  logic                rbank;
  logic [1:0]          full;
  logic                dropping;
  rd_state_t           state;

  logic                release_now;
  logic                first_sample;
  logic                admit;
  logic                wr;
  logic [LOG2N-1:0]    rd_addr;
  logic                rd_bank;
  logic                load;
  logic [2*DATA_W-1:0] rdata [2];
  logic [2*DATA_W-1:0] rd_data;

  assign release_now  = (state == STREAM) && do_valid && do_ready && do_last;
  assign first_sample = di_en && (wcnt == '0);
  // A bank being released this very cycle already has its last entry in the output register.
  assign admit        = !full[wbank] || (release_now && (rbank == wbank));
  assign wr           = di_en && (first_sample ? admit : !dropping);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank u_bank (
      .clk   (clk),
      .en    (wr && (wbank == 1'(b))),
      .addr  (bitrev(wcnt)),
      .data  ({di_re, di_im}),
      .raddr (rd_addr),
      .rdata (rdata[b])
    );
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    rd_bank = rbank;
    rd_addr = '0;
    load    = 1'b0;
    case (state)
      IDLE:   load = full[rbank];
      STREAM: begin
        if (do_valid && do_ready) begin
          if (do_last) begin
            rd_bank = ~rbank;
            load    = full[~rbank];
          end else begin
            rd_addr = do_index + 1'b1;
            load    = 1'b1;
          end
        end
      end
      default: load = 1'b0;
    endcase
  end

  assign rd_data = rdata[rd_bank];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt       <= '0;
      wbank      <= 1'b0;
      dropping   <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= first_sample && !admit;
      if (!di_en) begin
        wcnt     <= '0;
        dropping <= 1'b0;
      end else begin
        wcnt <= wcnt + 1'b1;
        if (first_sample) dropping <= !admit;
        if (wr && (wcnt == LAST_BIN)) wbank <= ~wbank;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rbank    <= 1'b0;
      full     <= 2'b00;
      do_valid <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
      do_index <= '0;
      do_last  <= 1'b0;
    end else begin
      if (wr && (wcnt == LAST_BIN)) full[wbank] <= 1'b1;
      if (release_now) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end

      if (load) begin
        state    <= STREAM;
        do_valid <= 1'b1;
        do_re    <= rd_data[2*DATA_W-1:DATA_W];
        do_im    <= rd_data[DATA_W-1:0];
        do_index <= rd_addr;
        do_last  <= (rd_addr == LAST_BIN);
      end else if (release_now) begin
        state    <= IDLE;
        do_valid <= 1'b0;
        do_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder_reader.sv
// Randomized self-checking bench: frames are modelled as natural-order arrays,
// fed in bit-reversed order, and the accepted output stream is scored against them.
module tb_fft_reorder_reader;
  import fft_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              di_en;
  logic [DATA_W-1:0] di_re, di_im;
  logic              do_valid;
  logic              do_ready;
  logic [DATA_W-1:0] do_re, do_im;
  logic [LOG2N-1:0]  do_index;
  logic              do_last;
  logic              frame_drop;

  fft_reorder_reader dut (
    .clk(clk), .rst(rst), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_valid(do_valid), .do_ready(do_ready), .do_re(do_re), .do_im(do_im),
    .do_index(do_index), .do_last(do_last), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [3:0]  idx;
    logic        last;
  } smp_t;

  int   total = 0;
  int   bad   = 0;
  smp_t got[$];
  smp_t exp_q[$];
  logic [15:0] fr_re [16];
  logic [15:0] fr_im [16];

  int ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: never ready
  int rdy_phase  = 0;
  int drop_pulses, stall_err, stall_cycles, run_len, max_run;
  logic        held;
  logic [36:0] held_v;

  function automatic logic [3:0] rev4(input logic [3:0] k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = k[3-i];
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       do_ready = 1'b1;
      1: begin
        do_ready  = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
        rdy_phase = rdy_phase + 1;
      end
      default: do_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      held    = 1'b0;
      run_len = 0;
    end else begin
      if (frame_drop) drop_pulses++;
      if (do_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else run_len = 0;
      if (held && do_valid && ({do_re, do_im, do_index, do_last} !== held_v)) stall_err++;
      if (do_valid && do_ready) begin
        got.push_back('{re: do_re, im: do_im, idx: do_index, last: do_last});
        held = 1'b0;
      end else if (do_valid) begin
        held   = 1'b1;
        held_v = {do_re, do_im, do_index, do_last};
        stall_cycles++;
      end else held = 1'b0;
    end
  end

  task automatic rand_frame();
    for (int b = 0; b < 16; b++) begin
      fr_re[b] = 16'($urandom);
      fr_im[b] = 16'($urandom);
    end
  endtask

  task automatic push_expected();
    for (int b = 0; b < 16; b++)
      exp_q.push_back('{re: fr_re[b], im: fr_im[b], idx: 4'(b), last: (b == 15)});
  endtask

  // Input cycle k carries bin rev(k): the FFT's bit-reversed output order.
  task automatic drive(input int n, input bit gap_after);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      di_en = 1'b1;
      di_re = fr_re[rev4(4'(k))];
      di_im = fr_im[rev4(4'(k))];
    end
    if (gap_after) begin
      @(posedge clk); #1;
      di_en = 1'b0;
    end
  endtask

  task automatic drain_and_compare(input string name, input int budget);
    int n = exp_q.size();
    int t = 0;
    while (got.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (got.size() != n) begin
      bad++;
      $display("FAIL %s count: got %0d samples, expected %0d", name, got.size(), n);
    end
    for (int i = 0; i < n && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s sample %0d: got re=%h im=%h idx=%0d last=%b, expected re=%h im=%h idx=%0d last=%b",
                 name, i, got[i].re, got[i].im, got[i].idx, got[i].last,
                 exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last);
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({do_valid, do_re, do_im, do_index, do_last, frame_drop} !== '0) begin
      bad++;
      $display("FAIL %s: got valid=%b re=%h im=%h idx=%0d last=%b drop=%b, expected all zero",
               name, do_valid, do_re, do_im, do_index, do_last, frame_drop);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; di_en = 1'b0; di_re = '0; di_im = '0; do_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    for (int b = 0; b < 16; b++) begin
      fr_re[b] = 16'(b * 10);
      fr_im[b] = 16'($urandom);
    end
    push_expected();
    max_run = 0;
    drive(16, 1'b1);
    @(negedge clk);
    total++;
    if (do_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: do_valid=%b one cycle after last input, expected 0", do_valid);
    end
    @(negedge clk);
    total++;
    if (do_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency_t2: do_valid=%b two cycles after last input, expected 1", do_valid);
    end
    drain_and_compare("single_frame", 100);
  endtask

  task automatic test_back_to_back();
    max_run = 0;
    rand_frame(); push_expected(); drive(16, 1'b0);
    rand_frame(); push_expected(); drive(16, 1'b1);
    drain_and_compare("back_to_back", 100);
    total++;
    if (max_run != 32) begin
      bad++;
      $display("FAIL back_to_back_gapless: longest valid run %0d, expected 32", max_run);
    end
  endtask

  task automatic test_backpressure();
    rdy_phase = 0; stall_err = 0; stall_cycles = 0;
    ready_mode = 1;
    rand_frame(); push_expected(); drive(16, 1'b1);
    rand_frame(); push_expected(); drive(16, 1'b1);
    drain_and_compare("backpressure", 300);
    ready_mode = 0;
    total++;
    if (stall_err != 0) begin
      bad++;
      $display("FAIL backpressure_hold: %0d output changes while stalled, expected 0", stall_err);
    end
    total++;
    if (stall_cycles == 0) begin
      bad++;
      $display("FAIL backpressure_stalls: %0d stalled cycles seen, expected some", stall_cycles);
    end
  endtask

  task automatic test_overflow();
    ready_mode = 2;
    repeat (2) @(posedge clk);
    drop_pulses = 0;
    rand_frame(); push_expected(); drive(16, 1'b1);
    rand_frame(); push_expected(); drive(16, 1'b1);
    rand_frame();                  drive(16, 1'b1);
    repeat (5) @(negedge clk);
    total++;
    if (drop_pulses != 1) begin
      bad++;
      $display("FAIL overflow_drop: %0d frame_drop cycles, expected 1", drop_pulses);
    end
    total++;
    if (got.size() != 0) begin
      bad++;
      $display("FAIL overflow_stalled: %0d samples accepted with ready low, expected 0", got.size());
    end
    ready_mode = 0;
    drain_and_compare("overflow", 200);
  endtask

  task automatic test_partial();
    drop_pulses = 0;
    rand_frame(); drive(7, 1'b1);
    rand_frame(); push_expected(); drive(16, 1'b1);
    drain_and_compare("partial", 100);
    total++;
    if (drop_pulses != 0) begin
      bad++;
      $display("FAIL partial_drop: %0d frame_drop cycles, expected 0", drop_pulses);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    drop_pulses = 0;
    rand_frame(); drive(16, 1'b1);
    while (!(do_valid === 1'b1 && do_index === 4'd5) && t < 60) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t >= 60) begin
      bad++;
      $display("FAIL reset_mid_reach: bin 5 not seen within 60 cycles, expected it");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    exp_q.delete();
    total++;
    if (drop_pulses != 0) begin
      bad++;
      $display("FAIL reset_mid_drop: %0d frame_drop cycles, expected 0", drop_pulses);
    end
    rand_frame(); push_expected(); drive(16, 1'b1);
    drain_and_compare("after_reset", 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drop_pulses = 0; stall_err = 0; stall_cycles = 0; run_len = 0; max_run = 0; held = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_partial();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
